// File: rtl/llfifo_pop_scheduler_if.sv
// Bundle of the FIFO-side and stream-side signals of the pop scheduler.
//   count       : per-FIFO occupancy, field g = [(g+1)*LOG2_DEPTH-1 -: LOG2_DEPTH]
//   enable_mask : bit g=1 lets FIFO g be scheduled
//   fifo_q      : FIFO read data, valid the cycle after a pop
//   pop/pop_fifo: pop request and FIFO index (index is 0 when pop=0)
//   out_valid/out_ready/out_data/out_fifo : tagged output stream
// The master modport is the scheduler; the slave modport is its environment
// (the FIFO plus the downstream consumer).
interface llfifo_pop_scheduler_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int LOG2_FIFOS = $clog2(FIFOS),
  parameter int LOG2_DEPTH = $clog2(DEPTH)
);
  logic [LOG2_DEPTH*FIFOS-1:0] count;
  logic [FIFOS-1:0]            enable_mask;
  logic [WIDTH-1:0]            fifo_q;
  logic                        pop;
  logic [LOG2_FIFOS-1:0]       pop_fifo;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [LOG2_FIFOS-1:0]       out_fifo;

  modport master (
    input  count, enable_mask, fifo_q, out_ready,
    output pop, pop_fifo, out_valid, out_data, out_fifo
  );

  modport slave (
    output count, enable_mask, fifo_q, out_ready,
    input  pop, pop_fifo, out_valid, out_data, out_fifo
  );
endinterface

// File: rtl/llfifo_pop_scheduler.sv
// Drain stage for the linked-list multi-FIFO.
// Picks a non-empty, enabled FIFO by round-robin, pops it, captures the
// one-cycle-late read data into a 3-entry tagged buffer and presents the
// buffer head on a valid/ready stream. Pops are throttled so that every
// popped item always has a buffer slot waiting for it.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : llfifo_pop_scheduler_if.master (count, enable_mask, fifo_q,
//         pop, pop_fifo, out_valid, out_ready, out_data, out_fifo)
module llfifo_pop_scheduler #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int LOG2_FIFOS = $clog2(FIFOS),
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  llfifo_pop_scheduler_if.master bus
);

  localparam logic [LOG2_FIFOS:0]   FIFOS_EXT = (LOG2_FIFOS+1)'(FIFOS);
  localparam logic [LOG2_FIFOS-1:0] LAST_FIFO = LOG2_FIFOS'(FIFOS - 1);

  // Scheduler state
  logic [LOG2_FIFOS-1:0] rr_ptr_reg;
  logic                  inflight_reg;
  logic [LOG2_FIFOS-1:0] inflight_fifo_reg;

  // Output buffer state (3-entry circular buffer)
  logic [1:0]            rd_ptr_reg;
  logic [1:0]            wr_ptr_reg;
  logic [1:0]            occ_reg;
  logic [WIDTH-1:0]      buf_data_reg [0:2];
  logic [LOG2_FIFOS-1:0] buf_fifo_reg [0:2];

  logic [FIFOS-1:0]      eligible;
  logic                  grant_found;
  logic [LOG2_FIFOS-1:0] grant_idx;
  logic [LOG2_FIFOS:0]   idx_ext;
  logic [2:0]            pending;
  logic                  issue;
  logic                  capture;
  logic                  dequeue;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  for (genvar gi = 0; gi < FIFOS; gi++) begin : g_elig
    assign eligible[gi] = bus.enable_mask[gi] &&
                          (bus.count[(gi+1)*LOG2_DEPTH-1 -: LOG2_DEPTH] != '0);
  end

  // First eligible FIFO at or after rr_ptr, modulo FIFOS. The index is
  // computed one bit wider so the wrap works for non-power-of-2 FIFOS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_ext     = '0;
    for (int i = 0; i < FIFOS; i++) begin
      idx_ext = {1'b0, rr_ptr_reg} + (LOG2_FIFOS+1)'(i);
      if (idx_ext >= FIFOS_EXT) begin
        idx_ext = idx_ext - FIFOS_EXT;
      end
      if (!grant_found && eligible[idx_ext[LOG2_FIFOS-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_ext[LOG2_FIFOS-1:0];
      end
    end
  end

  // Reserve a buffer slot for the item in flight as well as the ones
  // already stored; out_ready deliberately plays no part here so pop has
  // no combinational path from the consumer.
  assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign issue   = !rst && grant_found && (pending < 3'd3);

  assign bus.pop      = issue;
  assign bus.pop_fifo = issue ? grant_idx : '0;

  assign capture = inflight_reg;
  assign dequeue = (occ_reg != 2'd0) && bus.out_ready;

  assign bus.out_valid = (occ_reg != 2'd0);
  assign bus.out_data  = buf_data_reg[rd_ptr_reg];
  assign bus.out_fifo  = buf_fifo_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_fifo_reg <= '0;
      rd_ptr_reg        <= 2'd0;
      wr_ptr_reg        <= 2'd0;
      occ_reg           <= 2'd0;
    end else begin
      if (issue) begin
        rr_ptr_reg        <= (grant_idx == LAST_FIFO) ? '0 : grant_idx + LOG2_FIFOS'(1);
        inflight_reg      <= 1'b1;
        inflight_fifo_reg <= grant_idx;
      end else begin
        inflight_reg <= 1'b0;
      end

      if (capture) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (dequeue) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end

      case ({capture, dequeue})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Buffer payload needs no reset: entries are only read while occ covers them.
  // Gating with rst drops an item whose pop preceded the reset.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      buf_data_reg[wr_ptr_reg] <= bus.fifo_q;
      buf_fifo_reg[wr_ptr_reg] <= inflight_fifo_reg;
    end
  end

endmodule

// File: tb/tb_llfifo_pop_scheduler.sv
module tb_llfifo_pop_scheduler;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int FIFOS = 8;
  localparam int LF    = 3;
  localparam int LD    = 5;

  logic clk = 1'b0;
  logic rst;
  logic rst5;
  always #5 clk = ~clk;

  llfifo_pop_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS)) bus ();
  llfifo_pop_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Second instance with a non-power-of-2 FIFO count, driven directly
  llfifo_pop_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(5)) bus5 ();
  llfifo_pop_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(5)) u_dut5 (
    .clk(clk), .rst(rst5), .bus(bus5)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0]    fq [FIFOS][$];   // contents of each logical FIFO
  logic [LF+WIDTH-1:0] outq [$];        // items delivered but not yet consumed
  int                  rr = 0;
  bit                  infl = 0;
  int                  infl_fifo = 0;
  logic [WIDTH-1:0]    infl_data = '0;
  bit                  rec_valid = 0, rec_pop = 0, rec_deq = 0, rec_rst = 0;
  bit                  model_live = 0;
  int                  rec_grant = 0;
  int                  deq_count = 0;

  always @(negedge clk) begin : model_compare
    logic [WIDTH-1:0]    d;
    logic [LF+WIDTH-1:0] head;
    bit                  popped, found, exp_pop, exp_valid;
    int                  grant;
    d = '0;
    popped = 0;
    // Apply what happened at the edge that just passed
    if (rec_valid) begin
      if (rec_rst) begin
        outq.delete();
        infl = 0;
        rr = 0;
        model_live = 1;
      end else begin
        if (rec_deq) begin
          void'(outq.pop_front());
          deq_count++;
        end
        if (infl) outq.push_back({LF'(infl_fifo), infl_data});
        if (rec_pop) begin
          if (fq[rec_grant].size() > 0) d = fq[rec_grant].pop_front();
          infl = 1;
          infl_fifo = rec_grant;
          infl_data = d;
          rr = (rec_grant + 1) % FIFOS;
          popped = 1;
        end else begin
          infl = 0;
        end
      end
    end
    // FIFO side: read data appears the cycle after a pop, junk otherwise
    bus.fifo_q = popped ? d : WIDTH'($urandom);
    for (int g = 0; g < FIFOS; g++) bus.count[g*LD +: LD] = LD'(fq[g].size());
    #1;
    found = 0;
    grant = 0;
    for (int i = 0; i < FIFOS; i++) begin
      int g;
      g = (rr + i) % FIFOS;
      if (!found && bus.enable_mask[g] && fq[g].size() != 0) begin
        found = 1;
        grant = g;
      end
    end
    exp_pop   = !rst && (outq.size() + int'(infl) < 3) && found;
    exp_valid = outq.size() != 0;
    if (model_live) begin
      check("pop", int'(bus.pop), int'(exp_pop));
      check("pop_fifo", int'(bus.pop_fifo), exp_pop ? grant : 0);
      check("out_valid", int'(bus.out_valid), int'(exp_valid));
      if (exp_valid) begin
        head = outq[0];
        check("out_fifo", int'(bus.out_fifo), int'(head[LF+WIDTH-1 -: LF]));
        check("out_data", int'(bus.out_data), int'(head[WIDTH-1:0]));
      end
    end
    rec_pop   = exp_pop;
    rec_grant = grant;
    rec_deq   = exp_valid && bus.out_ready;
    rec_rst   = rst;
    rec_valid = 1;
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after posedge; literal peeks happen after the model compare.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic peek();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(1);
    rst = 1'b1;
    for (int g = 0; g < FIFOS; g++) fq[g].delete();
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic step5(input logic [5*LD-1:0] c, input logic [WIDTH-1:0] q);
    @(negedge clk);
    bus5.count  = c;
    bus5.fifo_q = q;
    #1;
  endtask

  function automatic logic [5*LD-1:0] cnt5(input int a, input int b);
    logic [5*LD-1:0] c;
    c = '0;
    if (a >= 0) c[a*LD +: LD] = LD'(1);
    if (b >= 0) c[b*LD +: LD] = LD'(1);
    return c;
  endfunction

  initial begin
    int order [9];
    int npops;
    rst = 1'b1;
    rst5 = 1'b1;
    bus.enable_mask = '1;
    bus.out_ready = 1'b1;
    bus5.enable_mask = '1;
    bus5.out_ready = 1'b1;
    bus5.count = '0;
    bus5.fifo_q = '0;

    // Five-FIFO instance: walk rr_ptr to 4, then FIFOs 4 and 0 must be served 4 then 0
    repeat (2) @(negedge clk);
    rst5 = 1'b0;
    step5(cnt5(3, -1), 8'h00);
    check("w5_pop_a", int'(bus5.pop), 1);
    check("w5_fifo_a", int'(bus5.pop_fifo), 3);
    step5(cnt5(-1, -1), 8'hA3);
    check("w5_pop_b", int'(bus5.pop), 0);
    step5(cnt5(4, 0), 8'h5A);
    check("w5_fifo_c", int'(bus5.pop_fifo), 4);
    check("w5_valid_c", int'(bus5.out_valid), 1);
    check("w5_tag_c", int'(bus5.out_fifo), 3);
    check("w5_data_c", int'(bus5.out_data), 'hA3);
    step5(cnt5(0, -1), 8'hA4);
    check("w5_pop_d", int'(bus5.pop), 1);
    check("w5_fifo_d", int'(bus5.pop_fifo), 0);
    check("w5_valid_d", int'(bus5.out_valid), 0);
    step5(cnt5(-1, -1), 8'hA0);
    check("w5_pop_e", int'(bus5.pop), 0);
    check("w5_tag_e", int'(bus5.out_fifo), 4);
    check("w5_data_e", int'(bus5.out_data), 'hA4);
    step5(cnt5(-1, -1), 8'h77);
    check("w5_tag_f", int'(bus5.out_fifo), 0);
    check("w5_data_f", int'(bus5.out_data), 'hA0);
    step5(cnt5(-1, -1), 8'h66);
    check("w5_valid_g", int'(bus5.out_valid), 0);

    // Single item from FIFO 3: pop in cycle 0, output in cycle 2
    do_reset();
    fq[3].push_back(8'h3C);
    peek();
    check("single_pop", int'(bus.pop), 1);
    check("single_fifo", int'(bus.pop_fifo), 3);
    peek();
    check("single_pop_c1", int'(bus.pop), 0);
    check("single_valid_c1", int'(bus.out_valid), 0);
    peek();
    check("single_valid_c2", int'(bus.out_valid), 1);
    check("single_tag_c2", int'(bus.out_fifo), 3);
    check("single_data_c2", int'(bus.out_data), 'h3C);
    peek();
    check("single_valid_c3", int'(bus.out_valid), 0);

    // Round-robin over FIFOs 1, 4, 6
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fq[1].push_back(WIDTH'(8'h10 + k));
      fq[4].push_back(WIDTH'(8'h40 + k));
      fq[6].push_back(WIDTH'(8'h60 + k));
    end
    order = '{1, 4, 6, 1, 4, 6, 1, 4, 6};
    for (int k = 0; k < 9; k++) begin
      peek();
      check("rr_pop", int'(bus.pop), 1);
      check("rr_order", int'(bus.pop_fifo), order[k]);
    end
    peek();
    check("rr_done", int'(bus.pop), 0);
    cyc(4);

    // Backpressure: 10 items in FIFO 0, consumer stalled
    do_reset();
    bus.out_ready = 1'b0;
    deq_count = 0;
    for (int k = 0; k < 10; k++) fq[0].push_back(WIDTH'(8'h80 + k));
    npops = 0;
    for (int k = 0; k < 8; k++) begin
      peek();
      if (bus.pop) npops++;
    end
    check("bp_pops", npops, 3);
    check("bp_valid", int'(bus.out_valid), 1);
    check("bp_head", int'(bus.out_data), 'h80);
    cyc(1);
    bus.out_ready = 1'b1;
    cyc(14);
    peek();
    check("bp_drained", deq_count, 10);
    check("bp_idle", int'(bus.out_valid), 0);

    // Mask: FIFO 5 disabled until its bit is set
    do_reset();
    bus.enable_mask = 8'b1101_1111;
    fq[2].push_back(8'h22);
    fq[5].push_back(8'h55);
    peek();
    check("mask_first", int'(bus.pop_fifo), 2);
    peek();
    check("mask_block", int'(bus.pop), 0);
    cyc(1);
    bus.enable_mask = '1;
    peek();
    check("mask_pop5", int'(bus.pop), 1);
    check("mask_fifo5", int'(bus.pop_fifo), 5);
    cyc(4);

    // Reset with occ=2 and one item in flight
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) fq[0].push_back(WIDTH'(8'hC0 + k));
    fq[3].push_back(8'hD3);
    repeat (3) peek();
    cyc(1);
    rst = 1'b1;
    peek();
    check("rst_pop", int'(bus.pop), 0);
    cyc(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    peek();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_resume", int'(bus.pop_fifo), 0);
    cyc(10);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(1);
      rst = ($urandom_range(0, 299) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.enable_mask = ($urandom_range(0, 3) == 0) ? FIFOS'($urandom) : '1;
      repeat (2) begin
        if ($urandom_range(0, 2) == 0) begin
          int g;
          g = $urandom_range(0, FIFOS - 1);
          if (fq[g].size() < 20) fq[g].push_back(WIDTH'($urandom));
        end
      end
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
